// File: rtl/spart.sv
// Mini SPART bus-side responder: register decode, programmable baud generator,
// 8N1 UART transmitter and 16x-oversampled UART receiver.
module spart #(
   parameter logic [15:0] DB_RST = 16'd325
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   inout  wire  [7:0] databus,
   output logic       rda,
   output logic       tbr,
   output logic       txd,
   input  logic       rxd
);

   typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // Reload value for the baud down counter; divisors 0 and 1 both mean
   // "enable every cycle", so they reload 0 instead of wrapping.
   function automatic logic [15:0] reload_val(input logic [15:0] d);
      return (d <= 16'd1) ? 16'd0 : d - 16'd1;
   endfunction

   logic        bus_rd;
   logic        bus_wr;
   logic [7:0]  rd_data;
   logic [15:0] divisor;
   logic [15:0] div_new;
   logic        div_wr;
   logic [15:0] baud_cnt;
   logic        baud_en;

   tx_state_t   tx_state, tx_state_nxt;
   logic [9:0]  tx_frame, tx_frame_nxt;
   logic [3:0]  tx_en_cnt, tx_en_cnt_nxt;
   logic [3:0]  tx_bit_cnt, tx_bit_cnt_nxt;
   logic        tbr_nxt;
   logic        tx_load;

   logic        rx_meta;
   logic        rx_sync;
   rx_state_t   rx_state, rx_state_nxt;
   logic [3:0]  rx_en_cnt, rx_en_cnt_nxt;
   logic [2:0]  rx_bit_cnt, rx_bit_cnt_nxt;
   logic [7:0]  rx_shift, rx_shift_nxt;
   logic [7:0]  rx_buf;
   logic        rx_done;
   logic        rda_nxt;

   assign bus_rd  = iocs & iorw;
   assign bus_wr  = iocs & ~iorw;
   assign div_wr  = bus_wr & ioaddr[1];
   assign div_new = ioaddr[0] ? {databus, divisor[7:0]} : {divisor[15:8], databus};
   assign baud_en = (baud_cnt == 16'd0);
   assign tx_load = bus_wr & (ioaddr == 2'b00) & tbr;
   assign txd     = (tx_state == TX_SHIFT) ? tx_frame[0] : 1'b1;

   // Read-data mux; the bus is only driven during a selected read.
   always_comb begin
      rd_data = 8'h00;
      case (ioaddr)
         2'b00:   rd_data = rx_buf;
         2'b01:   rd_data = {6'b0, tbr, rda};
         2'b10:   rd_data = divisor[7:0];
         default: rd_data = divisor[15:8];
      endcase
   end

   assign databus = bus_rd ? rd_data : 8'hzz;

   // Divisor register, byte-writable from the bus.
   always_ff @(posedge clk) begin
      if (rst)
         divisor <= DB_RST;
      else if (div_wr)
         divisor <= div_new;
   end

   // Baud down counter; a divisor write restarts the period immediately.
   always_ff @(posedge clk) begin
      if (rst)
         baud_cnt <= 16'd0;
      else if (div_wr)
         baud_cnt <= reload_val(div_new);
      else if (baud_en)
         baud_cnt <= reload_val(divisor);
      else
         baud_cnt <= baud_cnt - 16'd1;
   end

   // Transmit FSM next-state: frame is shifted out LSB first, 16 enables per bit.
   always_comb begin
      tx_state_nxt   = tx_state;
      tx_frame_nxt   = tx_frame;
      tx_en_cnt_nxt  = tx_en_cnt;
      tx_bit_cnt_nxt = tx_bit_cnt;
      tbr_nxt        = tbr;
      case (tx_state)
         TX_IDLE: begin
            if (tx_load) begin
               tx_state_nxt   = TX_SHIFT;
               tx_frame_nxt   = {1'b1, databus, 1'b0};
               tx_en_cnt_nxt  = 4'd0;
               tx_bit_cnt_nxt = 4'd0;
               tbr_nxt        = 1'b0;
            end
         end
         default: begin
            if (baud_en) begin
               if (tx_en_cnt == 4'd15) begin
                  tx_en_cnt_nxt = 4'd0;
                  if (tx_bit_cnt == 4'd9) begin
                     tx_state_nxt = TX_IDLE;
                     tbr_nxt      = 1'b1;
                  end else begin
                     tx_frame_nxt   = {1'b1, tx_frame[9:1]};
                     tx_bit_cnt_nxt = tx_bit_cnt + 4'd1;
                  end
               end else begin
                  tx_en_cnt_nxt = tx_en_cnt + 4'd1;
               end
            end
         end
      endcase
   end

   // Transmit FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state   <= TX_IDLE;
         tx_frame   <= 10'h3ff;
         tx_en_cnt  <= 4'd0;
         tx_bit_cnt <= 4'd0;
         tbr        <= 1'b1;
      end else begin
         tx_state   <= tx_state_nxt;
         tx_frame   <= tx_frame_nxt;
         tx_en_cnt  <= tx_en_cnt_nxt;
         tx_bit_cnt <= tx_bit_cnt_nxt;
         tbr        <= tbr_nxt;
      end
   end

   // Two-flop synchroniser for the asynchronous serial input.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rxd;
         rx_sync <= rx_meta;
      end
   end

   // Receive FSM next-state: centre on the start bit, then sample mid-bit.
   always_comb begin
      rx_state_nxt   = rx_state;
      rx_en_cnt_nxt  = rx_en_cnt;
      rx_bit_cnt_nxt = rx_bit_cnt;
      rx_shift_nxt   = rx_shift;
      rx_done        = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (!rx_sync) begin
               rx_state_nxt  = RX_START;
               rx_en_cnt_nxt = 4'd0;
            end
         end
         RX_START: begin
            if (baud_en) begin
               if (rx_en_cnt == 4'd7) begin
                  rx_en_cnt_nxt  = 4'd0;
                  rx_bit_cnt_nxt = 3'd0;
                  rx_state_nxt   = rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  rx_en_cnt_nxt = rx_en_cnt + 4'd1;
               end
            end
         end
         RX_DATA: begin
            if (baud_en) begin
               if (rx_en_cnt == 4'd15) begin
                  rx_en_cnt_nxt = 4'd0;
                  rx_shift_nxt  = {rx_sync, rx_shift[7:1]};
                  if (rx_bit_cnt == 3'd7)
                     rx_state_nxt = RX_STOP;
                  else
                     rx_bit_cnt_nxt = rx_bit_cnt + 3'd1;
               end else begin
                  rx_en_cnt_nxt = rx_en_cnt + 4'd1;
               end
            end
         end
         default: begin
            if (baud_en) begin
               if (rx_en_cnt == 4'd15) begin
                  rx_en_cnt_nxt = 4'd0;
                  rx_state_nxt  = RX_IDLE;
                  rx_done       = rx_sync;
               end else begin
                  rx_en_cnt_nxt = rx_en_cnt + 4'd1;
               end
            end
         end
      endcase
   end

   // A completed byte beats a simultaneous read of the receive buffer.
   always_comb begin
      rda_nxt = rda;
      if (rx_done)
         rda_nxt = 1'b1;
      else if (bus_rd && (ioaddr == 2'b00))
         rda_nxt = 1'b0;
   end

   // Receive FSM state register and receive buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state   <= RX_IDLE;
         rx_en_cnt  <= 4'd0;
         rx_bit_cnt <= 3'd0;
         rx_shift   <= 8'h00;
         rx_buf     <= 8'h00;
         rda        <= 1'b0;
      end else begin
         rx_state   <= rx_state_nxt;
         rx_en_cnt  <= rx_en_cnt_nxt;
         rx_bit_cnt <= rx_bit_cnt_nxt;
         rx_shift   <= rx_shift_nxt;
         rda        <= rda_nxt;
         if (rx_done)
            rx_buf <= rx_shift;
      end
   end

endmodule
